m24c16_seq: RTL and testbench

M24C16_SEQ -- requirements
Module: m24c16_seq

---
 rtl/m24c16_seq.sv | 161 ++++++++++++++++
 tb/tb_m24c16_seq.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m24c16_seq.sv
// Sequencer for 24C16 EEPROM page writes and random/sequential reads. It drives a
// byte-level bus engine one command at a time and waits out the internal write cycle.
module m24c16_seq #(
  parameter int TWR_CYCLES = 120000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [2:0] req_block,
  input  logic [7:0] req_addr,
  input  logic [3:0] req_len_m1,
  input  logic [7:0] wr_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic [7:0] eng_byte,
  output logic       eng_read,
  output logic       eng_start,
  output logic       eng_ack,
  output logic       eng_stop,
  output logic       eng_go,
  input  logic       eng_done,
  input  logic [7:0] eng_rdbyte,
  output logic       busy
);

  localparam int TW = (TWR_CYCLES < 2) ? 1 : $clog2(TWR_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, DSEL_W, ADDR, DSEL_R, RD, WR_WAIT, WR, TWR} state_t;

  state_t          r_state;
  logic            r_write;
  logic [2:0]      r_block;
  logic [7:0]      r_addr;
  logic [4:0]      r_rem;
  logic [TW-1:0]   r_twr_cnt;
  logic [7:0]      r_rd_data;
  logic            r_rd_valid;
  logic [7:0]      r_eng_byte;
  logic            r_eng_read;
  logic            r_eng_start;
  logic            r_eng_ack;
  logic            r_eng_stop;
  logic            r_eng_go;
  logic            w_final;

  assign w_final   = (r_rem == 5'd1);
  assign req_ready = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign wr_ready  = (r_state == WR_WAIT);
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign eng_byte  = r_eng_byte;
  assign eng_read  = r_eng_read;
  assign eng_start = r_eng_start;
  assign eng_ack   = r_eng_ack;
  assign eng_stop  = r_eng_stop;
  assign eng_go    = r_eng_go;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_write     <= 1'b0;
      r_block     <= 3'd0;
      r_addr      <= 8'd0;
      r_rem       <= 5'd0;
      r_twr_cnt   <= '0;
      r_rd_data   <= 8'd0;
      r_rd_valid  <= 1'b0;
      r_eng_byte  <= 8'd0;
      r_eng_read  <= 1'b0;
      r_eng_start <= 1'b0;
      r_eng_ack   <= 1'b0;
      r_eng_stop  <= 1'b0;
      r_eng_go    <= 1'b0;
    end else begin
      r_eng_go   <= 1'b0;
      r_rd_valid <= 1'b0;
      case (r_state)
        IDLE: if (req_valid) begin
          r_write     <= req_write;
          r_block     <= req_block;
          r_addr      <= req_addr;
          r_rem       <= {1'b0, req_len_m1} + 5'd1;
          r_state     <= DSEL_W;
          r_eng_go    <= 1'b1;
          r_eng_byte  <= {4'b1010, req_block, 1'b0};
          r_eng_read  <= 1'b0;
          r_eng_start <= 1'b1;
          r_eng_ack   <= 1'b1;
          r_eng_stop  <= 1'b0;
        end
        DSEL_W: if (eng_done) begin
          r_state     <= ADDR;
          r_eng_go    <= 1'b1;
          r_eng_byte  <= r_addr;
          r_eng_start <= 1'b0;
        end
        ADDR: if (eng_done) begin
          if (r_write) begin
            r_state <= WR_WAIT;
          end else begin
            r_state     <= DSEL_R;
            r_eng_go    <= 1'b1;
            r_eng_byte  <= {4'b1010, r_block, 1'b1};
            r_eng_start <= 1'b1;
          end
        end
        DSEL_R: if (eng_done) begin
          r_state     <= RD;
          r_eng_go    <= 1'b1;
          r_eng_byte  <= 8'd0;
          r_eng_read  <= 1'b1;
          r_eng_start <= 1'b0;
          r_eng_ack   <= !w_final;
          r_eng_stop  <= w_final;
        end
        RD: if (eng_done) begin
          // Capture the byte and chain the next read in the same cycle.
          r_rd_valid <= 1'b1;
          r_rd_data  <= eng_rdbyte;
          r_rem      <= r_rem - 5'd1;
          if (w_final) begin
            r_state <= IDLE;
          end else begin
            r_eng_go   <= 1'b1;
            r_eng_ack  <= (r_rem != 5'd2);
            r_eng_stop <= (r_rem == 5'd2);
          end
        end
        WR_WAIT: if (wr_valid) begin
          r_state     <= WR;
          r_eng_go    <= 1'b1;
          r_eng_byte  <= wr_data;
          r_eng_read  <= 1'b0;
          r_eng_start <= 1'b0;
          r_eng_ack   <= 1'b1;
          r_eng_stop  <= w_final;
        end
        WR: if (eng_done) begin
          r_rem <= r_rem - 5'd1;
          if (w_final) begin
            r_state   <= TWR;
            r_twr_cnt <= TW'(TWR_CYCLES);
          end else begin
            r_state <= WR_WAIT;
          end
        end
        TWR: begin
          if (r_twr_cnt == '0) r_state <= IDLE;
          else r_twr_cnt <= r_twr_cnt - 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m24c16_seq.sv
// Bench for m24c16_seq: a randomized byte-engine model answers commands, and every
// transaction is compared against a command/data list built from the protocol rules.
module tb_m24c16_seq;
  localparam int TWR = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [2:0] req_block = 3'd0;
  logic [7:0] req_addr = 8'd0;
  logic [3:0] req_len_m1 = 4'd0;
  logic [7:0] wr_data = 8'd0;
  logic       wr_valid = 1'b0;
  logic       eng_done = 1'b0;
  logic [7:0] eng_rdbyte = 8'd0;
  logic       req_ready, wr_ready, rd_valid, busy;
  logic [7:0] rd_data, eng_byte;
  logic       eng_read, eng_start, eng_ack, eng_stop, eng_go;

  m24c16_seq #(.TWR_CYCLES(TWR)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_block(req_block), .req_addr(req_addr),
    .req_len_m1(req_len_m1), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
    .eng_byte(eng_byte), .eng_read(eng_read), .eng_start(eng_start),
    .eng_ack(eng_ack), .eng_stop(eng_stop), .eng_go(eng_go),
    .eng_done(eng_done), .eng_rdbyte(eng_rdbyte), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int errors = 0;
  int checks = 0;

  logic [11:0] cmd_q[$];
  int          go_cyc_q[$];
  int          done_cyc_q[$];
  int          rd_cyc_q[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  eng_rd_q[$];
  logic [7:0]  rd_script[$];
  logic [7:0]  wr_script[$];
  int          delay_ovr = 0;
  int          spur_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Engine model: one command at a time, random completion latency.
  initial begin : engine
    int spur_done;
    int d;
    logic [11:0] c;
    spur_done = 0;
    forever begin
      @(posedge clock); #1;
      eng_done = 1'b0;
      if (spur_cnt > spur_done) begin
        spur_done++;
        eng_done = 1'b1;
      end else if (eng_go) begin
        c = {eng_read, eng_start, eng_ack, eng_stop, eng_byte};
        cmd_q.push_back(c);
        go_cyc_q.push_back(cyc);
        d = (delay_ovr > 0) ? delay_ovr : int'($urandom_range(1, 3));
        repeat (d) @(posedge clock);
        #1;
        if (c[11]) begin
          eng_rdbyte = (rd_script.size() > 0) ? rd_script.pop_front() : 8'($urandom);
          eng_rd_q.push_back(eng_rdbyte);
        end
        eng_done = 1'b1;
        done_cyc_q.push_back(cyc);
      end
    end
  end

  // Protocol monitor: single outstanding command, stable fields, read-data capture.
  logic        outst = 1'b0;
  logic [11:0] cap = 12'd0;
  always @(negedge clock) begin
    if (reset) begin
      outst = 1'b0;
    end else begin
      if (eng_go) begin
        chk("one_outstanding", 32'(outst), 32'd0);
        outst = 1'b1;
        cap = {eng_read, eng_start, eng_ack, eng_stop, eng_byte};
      end else if (outst) begin
        chk("fields_stable", 32'({eng_read, eng_start, eng_ack, eng_stop, eng_byte}), 32'(cap));
      end
      if (eng_done) outst = 1'b0;
      if (rd_valid) begin
        rd_q.push_back(rd_data);
        rd_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic clear_logs();
    cmd_q.delete(); go_cyc_q.delete(); done_cyc_q.delete();
    rd_cyc_q.delete(); rd_q.delete(); eng_rd_q.delete();
  endtask

  task automatic run_txn(input bit w, input logic [2:0] blk, input logic [7:0] addr,
                         input logic [3:0] lm1, input bit hold, input bit pulse);
    int len, n, ready_c, target;
    bit got;
    logic [7:0]  d[$];
    logic [11:0] exp[$];
    logic [11:0] m;
    len = int'(lm1) + 1;
    clear_logs();
    for (int i = 0; i < len; i++)
      d.push_back((wr_script.size() > 0) ? wr_script.pop_front() : 8'($urandom));
    // Expected command list: {read, start, ack, stop, byte}
    exp.push_back({4'b0110, 4'b1010, blk, 1'b0});
    exp.push_back({4'b0010, addr});
    if (!w) begin
      exp.push_back({4'b0110, 4'b1010, blk, 1'b1});
      for (int i = 0; i < len; i++)
        exp.push_back({1'b1, 1'b0, (i != len - 1), (i == len - 1), 8'h00});
    end else begin
      for (int i = 0; i < len; i++)
        exp.push_back({1'b0, 1'b0, 1'b1, (i == len - 1), d[i]});
    end

    req_write = w; req_block = blk; req_addr = addr; req_len_m1 = lm1;
    req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("go_after_accept", 32'(eng_go), 32'd1);
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("ready_low_after_accept", 32'(req_ready), 32'd0);

    if (w) begin
      for (int i = 0; i < len; i++) begin
        n = 0;
        while (!wr_ready && n < 200) begin @(posedge clock); #1; n++; end
        chk("wr_ready_wait", 32'(wr_ready), 32'd1);
        if (hold && i == 0) begin
          repeat (10) begin
            chk("hold_no_go", 32'(eng_go), 32'd0);
            chk("hold_wr_ready", 32'(wr_ready), 32'd1);
            chk("hold_busy", 32'(busy), 32'd1);
            @(posedge clock); #1;
          end
        end
        wr_data = d[i];
        wr_valid = 1'b1;
        @(posedge clock); #1;
        wr_valid = 1'b0;
      end
      if (pulse) begin
        n = 0;
        while (done_cyc_q.size() < exp.size() && n < 200) begin @(posedge clock); #1; n++; end
        target = done_cyc_q[$] + 2;
        n = 0;
        while (cyc < target && n < 20) begin @(posedge clock); #1; n++; end
        req_valid = 1'b1;
        @(posedge clock); #1;
        req_valid = 1'b0;
      end
    end

    got = 1'b0;
    n = 0;
    while (n < 400) begin
      @(negedge clock);
      if (req_ready) begin got = 1'b1; break; end
      n++;
    end
    chk("ready_return", 32'(got), 32'd1);
    ready_c = cyc;
    repeat (3) @(negedge clock);

    chk("cmd_count", cmd_q.size(), exp.size());
    for (int i = 0; i < cmd_q.size() && i < exp.size(); i++) begin
      m = exp[i][11] ? 12'hF00 : 12'hFFF;
      chk($sformatf("cmd%0d", i), 32'(cmd_q[i] & m), 32'(exp[i] & m));
    end
    if (done_cyc_q.size() == 0) begin
      chk("done_seen", 32'd0, 32'd1);
    end else if (!w) begin
      chk("rd_count", rd_q.size(), len);
      for (int i = 0; i < rd_q.size() && i < eng_rd_q.size(); i++) begin
        chk($sformatf("rd_data%0d", i), 32'(rd_q[i]), 32'(eng_rd_q[i]));
        chk($sformatf("rd_latency%0d", i), rd_cyc_q[i], done_cyc_q[3 + i] + 1);
      end
      for (int k = 4; k < go_cyc_q.size(); k++)
        chk($sformatf("rd_chain%0d", k), go_cyc_q[k], done_cyc_q[k - 1] + 1);
      chk("rd_idle_latency", ready_c, done_cyc_q[$] + 1);
    end else begin
      chk("wr_no_rd_valid", rd_q.size(), 0);
      chk("twr_latency", ready_c, done_cyc_q[$] + TWR + 2);
    end
    $display("txn write=%0d block=%0d addr=0x%02h len=%0d cmds=%0d rd=%0d ready_cycle=%0d",
             w, blk, addr, len, cmd_q.size(), rd_q.size(), ready_c);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_ready", 32'(wr_ready), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_eng_go", 32'(eng_go), 32'd0);
    chk("rst_eng_fields", 32'({eng_read, eng_start, eng_ack, eng_stop, eng_byte}), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    rd_script = '{8'hA1, 8'hA2, 8'hA3};
    run_txn(1'b0, 3'd3, 8'h40, 4'd2, 1'b0, 1'b0);

    wr_script = '{8'h55, 8'hAA};
    run_txn(1'b1, 3'd0, 8'h10, 4'd1, 1'b1, 1'b1);

    run_txn(1'b0, 3'd5, 8'hFF, 4'd0, 1'b0, 1'b0);

    // Spurious completion while idle must change nothing.
    @(posedge clock); #1;
    n = cmd_q.size();
    spur_cnt++;
    repeat (3) begin
      @(negedge clock);
      chk("spur_ready", 32'(req_ready), 32'd1);
      chk("spur_no_go", 32'(eng_go), 32'd0);
      chk("spur_no_rd", 32'(rd_valid), 32'd0);
    end
    chk("spur_no_cmd", cmd_q.size(), n);

    // Reset while the address byte is outstanding, then a late completion.
    @(posedge clock); #1;
    clear_logs();
    delay_ovr = 6;
    req_write = 1'b0; req_block = 3'd2; req_addr = 8'h33; req_len_m1 = 4'd3;
    req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    n = 0;
    while (go_cyc_q.size() < 2 && n < 100) begin @(posedge clock); #1; n++; end
    chk("abort_addr_issued", go_cyc_q.size(), 2);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_fields", 32'({eng_read, eng_start, eng_ack, eng_stop, eng_byte}), 32'd0);
    repeat (12) begin
      @(negedge clock);
      chk("abort_no_go", 32'(eng_go), 32'd0);
      chk("abort_no_rd", 32'(rd_valid), 32'd0);
      chk("abort_idle", 32'(req_ready), 32'd1);
    end
    chk("abort_cmd_count", cmd_q.size(), 2);
    $display("txn abort_on_reset cmds=%0d", cmd_q.size());
    delay_ovr = 0;
    @(posedge clock); #1;

    for (int t = 0; t < 8; t++)
      run_txn(1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom), 4'($urandom), 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
